// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared constants and the FSM state type for the iterative divider (iter_div).
// The 67-bit es_to_div_bus and 33-bit div_to_es_bus widths live in define.vh,
// next to the pipeline that packs them. They are not repeated here.
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int XLEN      = 32;  // operand / result width
  localparam int CNT_W     = 5;   // log2(XLEN), iteration counter width
  localparam int DIV_ITERS = 32;  // one quotient bit per BUSY cycle

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_sign_fix.sv
// -----------------------------------------------------------------------------
// div_sign_fix
// Combinational back end of the divider. It applies the operand signs to the
// unsigned quotient and remainder magnitudes, forces the divide-by-zero
// quotient, and selects quotient or remainder.
//
// Ports
//   quo_mag_i  in  XLEN  unsigned quotient magnitude
//   rem_mag_i  in  XLEN  unsigned remainder magnitude
//   neg_quo_i  in  1     operand signs differ (signed ops only)
//   neg_rem_i  in  1     dividend is negative (signed ops only)
//   div_zero_i in  1     divisor is zero
//   use_mod_i  in  1     1 = remainder, 0 = quotient
//   result_o   out XLEN  selected, sign-corrected result
// -----------------------------------------------------------------------------
module div_sign_fix #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] quo_mag_i,
  input  logic [XLEN-1:0] rem_mag_i,
  input  logic            neg_quo_i,
  input  logic            neg_rem_i,
  input  logic            div_zero_i,
  input  logic            use_mod_i,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;

  // NOTE: every variable written in an always_comb block gets a value on every
  // path. The plain assignments below cover this, so no latch is inferred.
  always_comb begin
    quo = neg_quo_i ? (~quo_mag_i + 1'b1) : quo_mag_i;
    rem = neg_rem_i ? (~rem_mag_i + 1'b1) : rem_mag_i;
    // With a zero divisor every trial subtraction succeeds. The magnitude then
    // shifts through untouched, so the remainder is |src1| and the dividend's
    // own sign turns it back into src1. Only the quotient needs an override.
    if (div_zero_i) begin
      quo = '1;
    end
    result_o = use_mod_i ? rem : quo;
  end

endmodule

// File: rtl/iter_div.sv
// -----------------------------------------------------------------------------
// iter_div
// Iterative radix-2 restoring divider for DIV.W / DIV.WU / MOD.W / MOD.WU.
// It produces one quotient bit per cycle:
//   cycle 0 IDLE (request captured), cycles 1-32 BUSY, cycle 33 FIX,
//   and div_ok rises at cycle 34.
// Dropping div_en before DONE aborts the divide without changing the result.
//
// Build option: define DIV_EARLY_OUT_EN to finish at cycle 1 when the divisor
// is nonzero and |dividend| < |divisor|. The quotient is then 0 and the
// remainder is src1.
//
// Ports
//   clk         in  1     clock
//   reset       in  1     synchronous, active-high reset
//   div_en      in  1     divide request, held until the result is retired
//   use_mod     in  1     1 = remainder, 0 = quotient
//   is_unsigned in  1     1 = unsigned, 0 = signed
//   src1        in  XLEN  dividend
//   src2        in  XLEN  divisor
//   div_ack     in  1     execute stage retires the result
//   div_result  out XLEN  quotient or remainder, held in DONE
//   div_ok      out 1     result valid, or no divide requested
// -----------------------------------------------------------------------------
module iter_div #(
  parameter int XLEN  = div_pkg::XLEN,
  parameter int CNT_W = div_pkg::CNT_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            div_en,
  input  logic            use_mod,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            div_ack,
  output logic [XLEN-1:0] div_result,
  output logic            div_ok
);

  import div_pkg::*;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  div_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] rem_q;      // partial remainder, always < divisor
  logic [XLEN-1:0] quo_q;      // dividend bits shift out, quotient bits shift in
  logic [XLEN-1:0] dvs_q;      // divisor magnitude
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic            use_mod_q;
  logic [XLEN-1:0] result_q;

  // Sign and magnitude of the live operands. These are only used in IDLE.
  logic            src1_neg;
  logic            src2_neg;
  logic [XLEN-1:0] src1_mag;
  logic [XLEN-1:0] src2_mag;

  always_comb begin
    src1_neg = ~is_unsigned & src1[XLEN-1];
    src2_neg = ~is_unsigned & src2[XLEN-1];
    src1_mag = src1_neg ? (~src1 + 1'b1) : src1;
    src2_mag = src2_neg ? (~src2 + 1'b1) : src2;
  end

  // One restoring step. The XLEN+1-bit trial subtraction shows its sign in
  // the top bit. A clear top bit means the divisor fit, so the quotient bit is 1.
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_d;
  logic [XLEN-1:0] quo_d;

  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, dvs_q};
    rem_d   = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    quo_d   = {quo_q[XLEN-2:0], ~trial[XLEN]};
  end

  // Inputs to the sign-fix stage. The registered datapath drives them in FIX.
  // With early-out built in, the live operands drive them while in IDLE.
  logic [XLEN-1:0] fix_quo_mag;
  logic [XLEN-1:0] fix_rem_mag;
  logic            fix_neg_quo;
  logic            fix_neg_rem;
  logic            fix_zero;
  logic            fix_mod;
  logic [XLEN-1:0] fix_result;

`ifdef DIV_EARLY_OUT_EN
  logic early_out;
  assign early_out = div_en && (src2_mag != '0) && (src1_mag < src2_mag);
`endif

  always_comb begin
    fix_quo_mag = quo_q;
    fix_rem_mag = rem_q;
    fix_neg_quo = neg_quo_q;
    fix_neg_rem = neg_rem_q;
    fix_zero    = (dvs_q == '0);
    fix_mod     = use_mod_q;
`ifdef DIV_EARLY_OUT_EN
    if (state_q == IDLE) begin
      fix_quo_mag = '0;
      fix_rem_mag = src1_mag;
      fix_neg_quo = 1'b0;
      fix_neg_rem = src1_neg;
      fix_zero    = 1'b0;
      fix_mod     = use_mod;
    end
`endif
  end

  div_sign_fix #(
    .XLEN (XLEN)
  ) u_sign_fix (
    .quo_mag_i  (fix_quo_mag),
    .rem_mag_i  (fix_rem_mag),
    .neg_quo_i  (fix_neg_quo),
    .neg_rem_i  (fix_neg_rem),
    .div_zero_i (fix_zero),
    .use_mod_i  (fix_mod),
    .result_o   (fix_result)
  );

  // NOTE: sequential state is assigned only with non-blocking (<=) assignments.
  // Every register reads its pre-edge value, whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the datapath registers are cleared by reset too. This makes the
      // first result after reset independent of whatever was in them before.
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      use_mod_q <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (div_en) begin
            use_mod_q <= use_mod;
            neg_quo_q <= src1_neg ^ src2_neg;
            neg_rem_q <= src1_neg;
            rem_q     <= '0;
            quo_q     <= src1_mag;
            dvs_q     <= src2_mag;
            cnt_q     <= '0;
`ifdef DIV_EARLY_OUT_EN
            if (early_out) begin
              result_q <= fix_result;
              state_q  <= DONE;
            end else begin
              state_q  <= BUSY;
            end
`else
            state_q   <= BUSY;
`endif
          end
        end
        BUSY: begin
          if (!div_en) begin
            state_q <= IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
              state_q <= FIX;
            end
          end
        end
        FIX: begin
          if (!div_en) begin
            state_q <= IDLE;
          end else begin
            result_q <= fix_result;
            state_q  <= DONE;
          end
        end
        DONE: begin
          // Leave DONE only on retire or withdrawal. This ensures a request
          // that stays high cannot start a second divide.
          if (div_ack || !div_en) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign div_result = result_q;
  // Combinational, so a non-divide instruction never waits on this unit.
  assign div_ok     = ~div_en | (state_q == DONE);

endmodule

// File: tb/tb_iter_div.sv
// -----------------------------------------------------------------------------
// tb_iter_div
// Self-checking bench for iter_div. A plain-arithmetic reference (SV / and %,
// plus the defined divide-by-zero and overflow results) supplies every
// expected value. Compile with DIV_EARLY_OUT_EN to check the early-out build.
// -----------------------------------------------------------------------------
module tb_iter_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        div_en;
  logic        use_mod;
  logic        is_unsigned;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        div_ack;
  logic [31:0] div_result;
  logic        div_ok;

  int checks   = 0;
  int failures = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  always #5 clk = ~clk;

  iter_div dut (
    .clk         (clk),
    .reset       (reset),
    .div_en      (div_en),
    .use_mod     (use_mod),
    .is_unsigned (is_unsigned),
    .src1        (src1),
    .src2        (src2),
    .div_ack     (div_ack),
    .div_result  (div_result),
    .div_ok      (div_ok)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Truncating division with the defined corner cases.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic m, input logic u);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (u) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return m ? r : q;
  endfunction

  function automatic int ref_latency(input logic [31:0] a, input logic [31:0] b, input logic u);
    longint ma;
    longint mb;
    ma = u ? longint'(a) : longint'($signed(a));
    mb = u ? longint'(b) : longint'($signed(b));
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    return (EARLY_OUT && mb != 0 && ma < mb) ? 1 : 34;
  endfunction

  // Issue one divide and wait for div_ok. Operands are scrambled mid-flight to
  // show they are captured. The result is held for 'hold' cycles before retiring.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic m, input logic u, input int hold);
    logic [31:0] exp_res;
    logic [31:0] held;
    int          exp_lat;
    int          lat;
    string       op;
    op      = $sformatf("%08h/%08h m%0d u%0d", a, b, m, u);
    exp_res = ref_div(a, b, m, u);
    exp_lat = ref_latency(a, b, u);
    @(negedge clk);
    div_en = 1'b1; use_mod = m; is_unsigned = u; src1 = a; src2 = b; div_ack = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 2) begin
        src1 = $urandom; src2 = $urandom; use_mod = ~m; is_unsigned = ~u;
      end
      if (div_ok) begin
        lat = k;
        break;
      end
    end
    check({"latency ", op}, 32'(lat), 32'(exp_lat));
    check({"result ", op}, div_result, exp_res);
    held = div_result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_result", div_result, held);
      check("hold_ok", {31'b0, div_ok}, 32'd1);
    end
    div_ack = 1'b1;
    @(negedge clk);
    // Back in IDLE with div_en still high, so div_ok must be low.
    check("ack_to_idle", {31'b0, div_ok}, 32'd0);
    div_ack = 1'b0;
    div_en  = 1'b0;
  endtask

  initial begin
    logic [31:0] prev;
    logic [31:0] ra;
    logic [31:0] rb;

    reset = 1'b1; div_en = 1'b0; use_mod = 1'b0; is_unsigned = 1'b0;
    src1 = '0; src2 = '0; div_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_result", div_result, 32'd0);
    check("reset_ok", {31'b0, div_ok}, 32'd1);
    reset = 1'b0;

    // Unsigned quotient / remainder.
    run_div(32'd100, 32'd7, 1'b0, 1'b1, 0);
    run_div(32'd100, 32'd7, 1'b1, 1'b1, 0);
    // Signed truncation.
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 0);
    // Signed overflow and divide by zero.
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    run_div(32'd5, 32'd0, 1'b0, 1'b0, 0);
    run_div(32'd5, 32'd0, 1'b1, 1'b0, 0);
    run_div(32'hFFFF_FFF9, 32'd0, 1'b1, 1'b0, 0);

    // Abort at cycle 10: no result update, then a fresh divide takes full latency.
    prev = div_result;
    @(negedge clk);
    div_en = 1'b1; use_mod = 1'b0; is_unsigned = 1'b1; src1 = 32'd1000; src2 = 32'd3;
    repeat (10) @(negedge clk);
    check("abort_busy_ok", {31'b0, div_ok}, 32'd0);
    div_en = 1'b0;
    #1;
    check("abort_ok_comb", {31'b0, div_ok}, 32'd1);
    @(negedge clk);
    check("abort_result_held", div_result, prev);
    run_div(32'd9, 32'd3, 1'b0, 1'b1, 0);

    // Reset at cycle 20 clears the result and returns to IDLE.
    @(negedge clk);
    div_en = 1'b1; use_mod = 1'b0; is_unsigned = 1'b1; src1 = 32'd1000; src2 = 32'd7;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_result", div_result, 32'd0);
    check("midreset_idle_ok", {31'b0, div_ok}, 32'd0);
    reset = 1'b0; div_en = 1'b0;
    run_div(32'd77, 32'd7, 1'b1, 1'b1, 0);

    // Hold in DONE with div_en high and no ack.
    run_div(32'd1234567, 32'd89, 1'b0, 1'b1, 3);

    // Early-out candidates (full latency when the option is not built).
    run_div(32'd3, 32'd10, 1'b0, 1'b1, 0);
    run_div(32'd3, 32'd10, 1'b1, 1'b1, 0);
    run_div(32'hFFFF_FFFD, 32'd10, 1'b1, 1'b0, 0);
    run_div(32'd0, 32'd10, 1'b0, 1'b0, 0);
    run_div(32'd10, 32'd0, 1'b0, 1'b1, 0);

    // Randomized operands against the reference.
    for (int n = 0; n < 16; n++) begin
      ra = $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = $urandom;
        default: rb = 32'hFFFF_FFFF;
      endcase
      run_div(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n % 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
